// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory bus for program_loader.
// master = stream source / observer, slave = the loader itself.
interface program_loader_if #(
    parameter int SIZE   = 32,
    parameter int ADDR_W = 9
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [SIZE-1:0]   imem_din;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_din,
        input  cpu_hold, done, err, words_loaded
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_din,
        output cpu_hold, done, err, words_loaded
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: packs a big-endian byte stream (header N, then N words) into imem from address 0.
// Optional trailing XOR checksum word is enabled with macro LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int SIZE      = 32,
    parameter int ADDR_W    = 9,
    parameter int MEM_DEPTH = 512
) (
    input logic             clk,
    input logic             reset,
    program_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_FIN,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_e;

    state_e            state_q;
    logic [1:0]        byteCnt_q;
    logic [SIZE-9:0]   shift_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   wordsLoaded_q;
    logic              inReady_q;
    logic              imemWe_q;
    logic [ADDR_W-1:0] imemAddr_q;
    logic [SIZE-1:0]   imemDin_q;
    logic              cpuHold_q;
    logic              done_q;
    logic              err_q;
`ifdef LOADER_CHECKSUM_EN
    logic [SIZE-1:0]   xorSum_q;
`endif

    logic            accept_d;
    logic            wordDone_d;
    logic            lastWord_d;
    logic [SIZE-1:0] word_d;

    assign accept_d   = bus.in_valid & inReady_q;
    assign word_d     = {shift_q, bus.in_data};
    assign wordDone_d = accept_d && (byteCnt_q == 2'd3);
    assign lastWord_d = (wordsLoaded_q + (ADDR_W+1)'(1)) == count_q;

    assign bus.in_ready     = inReady_q;
    assign bus.imem_we      = imemWe_q;
    assign bus.imem_addr    = imemAddr_q;
    assign bus.imem_din     = imemDin_q;
    assign bus.cpu_hold     = cpuHold_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.words_loaded = wordsLoaded_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            byteCnt_q     <= '0;
            shift_q       <= '0;
            count_q       <= '0;
            wordsLoaded_q <= '0;
            inReady_q     <= 1'b0;
            imemWe_q      <= 1'b0;
            imemAddr_q    <= '0;
            imemDin_q     <= '0;
            cpuHold_q     <= 1'b1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xorSum_q      <= '0;
`endif
        end else begin
            imemWe_q <= 1'b0;
            if (accept_d) begin
                shift_q   <= word_d[SIZE-9:0];
                byteCnt_q <= byteCnt_q + 2'd1;
            end

            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        state_q       <= S_HDR;
                        inReady_q     <= 1'b1;
                        cpuHold_q     <= 1'b1;
                        done_q        <= 1'b0;
                        err_q         <= 1'b0;
                        wordsLoaded_q <= '0;
                        byteCnt_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        xorSum_q      <= '0;
`endif
                    end
                end

                S_HDR: begin
                    if (wordDone_d) begin
                        if (word_d == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q   <= S_CHK;
`else
                            state_q   <= S_DONE;
                            inReady_q <= 1'b0;
                            done_q    <= 1'b1;
                            cpuHold_q <= 1'b0;
`endif
                        end else if (word_d > SIZE'(MEM_DEPTH)) begin
                            state_q   <= S_ERR;
                            inReady_q <= 1'b0;
                            err_q     <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                            count_q <= word_d[ADDR_W:0];
                        end
                    end
                end

                // The word count doubles as the write address of the word being completed.
                S_LOAD: begin
                    if (wordDone_d) begin
                        imemWe_q      <= 1'b1;
                        imemAddr_q    <= wordsLoaded_q[ADDR_W-1:0];
                        imemDin_q     <= word_d;
                        wordsLoaded_q <= wordsLoaded_q + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
                        xorSum_q      <= xorSum_q ^ word_d;
                        if (lastWord_d) state_q <= S_CHK;
`else
                        if (lastWord_d) begin
                            state_q   <= S_FIN;
                            inReady_q <= 1'b0;
                        end
`endif
                    end
                end

                // Release the CPU only after the final write cycle has gone out.
                S_FIN: begin
                    state_q   <= S_DONE;
                    done_q    <= 1'b1;
                    cpuHold_q <= 1'b0;
                end

`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (wordDone_d) begin
                        inReady_q <= 1'b0;
                        if (word_d == xorSum_q) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            cpuHold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
